// File: rtl/banked_data_memory_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banked_mem_pkg : default geometry and address-decode helpers for the
//                  banked data memory.                            Rev 1.0
// ----------------------------------------------------------------------------
package banked_mem_pkg;

  localparam int DFLT_DATA_W     = 16;
  localparam int DFLT_ADDR_W     = 16;
  localparam int DFLT_DEPTH      = 1024;
  localparam int DFLT_BANKS      = 4;
  localparam int DFLT_PORTS      = 3;
  localparam int DFLT_ADDR_SHIFT = 2;

  localparam int BANK_W = $clog2(DFLT_BANKS);
  localparam int ROW_W  = $clog2(DFLT_DEPTH / DFLT_BANKS);
  localparam int PORT_W = $clog2(DFLT_PORTS);

  // Banks interleave on the word index, so consecutive words land in consecutive banks.
  function automatic int unsigned bank_of(input logic [31:0] addr,
                                          input int unsigned shift = DFLT_ADDR_SHIFT,
                                          input int unsigned banks = DFLT_BANKS);
    return (addr >> shift) % banks;
  endfunction

  function automatic int unsigned row_of(input logic [31:0] addr,
                                         input int unsigned shift = DFLT_ADDR_SHIFT,
                                         input int unsigned banks = DFLT_BANKS);
    return (addr >> shift) / banks;
  endfunction

  function automatic logic in_range(input logic [31:0] addr,
                                    input int unsigned shift = DFLT_ADDR_SHIFT,
                                    input int unsigned depth = DFLT_DEPTH);
    return (addr >> shift) < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/banked_data_memory_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banked_data_memory_if : per-port req/gnt access bus of the banked memory.
//                                                                 Rev 1.0
// ----------------------------------------------------------------------------
interface banked_data_memory_if
  import banked_mem_pkg::*;
#(
  parameter int PORTS  = DFLT_PORTS,
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W
);
  logic [PORTS-1:0]             req;
  logic [PORTS-1:0]             we;
  logic [PORTS-1:0][ADDR_W-1:0] addr;
  logic [PORTS-1:0][DATA_W-1:0] wdata;
  logic [PORTS-1:0]             gnt;
  logic [PORTS-1:0]             rvalid;
  logic [PORTS-1:0][DATA_W-1:0] rdata;
  logic [PORTS-1:0]             err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface
`default_nettype wire

// File: rtl/banked_data_memory_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, one grant per cycle, pointer moves past
//              the winner.                                        Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int PORTS = 3,
  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  wire              clock,
  input  wire              nReset,
  input  wire  [PORTS-1:0] req,
  input  wire              taken,
  output logic [PORTS-1:0] gnt,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] winner;
  logic             found;

  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int k);
    int unsigned s;
    s = (32'(base) + k) % PORTS;
    return PTR_W'(s);
  endfunction

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (!found && req[slot(ptr, k)]) begin
        found            = 1'b1;
        winner           = slot(ptr, k);
        gnt[slot(ptr, k)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ptr <= '0;
    end else if (taken && found) begin
      ptr <= slot(winner, 1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/banked_data_memory.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banked_data_memory : PORTS requesters over BANKS word-interleaved single-port
//                      banks with per-bank round-robin arbitration.  Rev 1.0
// ----------------------------------------------------------------------------
module banked_data_memory
  import banked_mem_pkg::*;
#(
  parameter int DATA_W     = DFLT_DATA_W,
  parameter int ADDR_W     = DFLT_ADDR_W,
  parameter int DEPTH      = DFLT_DEPTH,
  parameter int BANKS      = DFLT_BANKS,
  parameter int PORTS      = DFLT_PORTS,
  parameter int ADDR_SHIFT = DFLT_ADDR_SHIFT
) (
  input wire clock,
  input wire nReset,
  banked_data_memory_if.slave bus
);

  localparam int ROWS      = DEPTH / BANKS;
  localparam int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_BITS  = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0][BANK_BITS-1:0] p_bank;
  logic [PORTS-1:0][ROW_BITS-1:0]  p_row;
  logic [PORTS-1:0]                p_inr;
  logic [PORTS-1:0]                bank_req [BANKS];
  logic [PORTS-1:0]                bank_gnt [BANKS];
  logic [DATA_W-1:0]               rd_word  [BANKS];

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      p_bank[p] = BANK_BITS'(bank_of(32'(bus.addr[p]), ADDR_SHIFT, BANKS));
      p_row[p]  = ROW_BITS'(row_of(32'(bus.addr[p]), ADDR_SHIFT, BANKS));
      p_inr[p]  = in_range(32'(bus.addr[p]), ADDR_SHIFT, DEPTH);
    end
    for (int b = 0; b < BANKS; b++) begin
      for (int p = 0; p < PORTS; p++) begin
        bank_req[b][p] = bus.req[p] & p_inr[p] & (p_bank[p] == BANK_BITS'(b));
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0]   mem [ROWS];
    logic [ROW_BITS-1:0] sel_row;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic [PTR_BITS-1:0] unused_ptr;

    rr_arbiter #(.PORTS(PORTS)) u_arb (
      .clock  (clock),
      .nReset (nReset),
      .req    (bank_req[b]),
      .taken  (|bank_req[b]),
      .gnt    (bank_gnt[b]),
      .ptr    (unused_ptr)
    );

    // The arbiter's one-hot grant steers the single bank port.
    always_comb begin
      sel_we    = 1'b0;
      sel_row   = '0;
      sel_wdata = '0;
      for (int p = 0; p < PORTS; p++) begin
        if (bank_gnt[b][p] && nReset) begin
          sel_we    = bus.we[p];
          sel_row   = p_row[p];
          sel_wdata = bus.wdata[p];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (sel_we) begin
        mem[sel_row] <= sel_wdata;
      end
    end

    assign rd_word[b] = mem[sel_row];
  end

  // Out-of-range requests skip arbitration and are granted at once.
  always_comb begin
    bus.gnt = '0;
    for (int p = 0; p < PORTS; p++) begin
      bus.gnt[p] = bus.req[p] & ~p_inr[p];
      for (int b = 0; b < BANKS; b++) begin
        bus.gnt[p] = bus.gnt[p] | bank_gnt[b][p];
      end
    end
    if (!nReset) begin
      bus.gnt = '0;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      bus.rvalid <= '0;
      bus.err    <= '0;
      bus.rdata  <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        bus.rvalid[p] <= bus.gnt[p] & ~bus.we[p];
        bus.err[p]    <= bus.gnt[p] & ~p_inr[p];
        if (bus.gnt[p] && !bus.we[p]) begin
          bus.rdata[p] <= p_inr[p] ? rd_word[p_bank[p]] : '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_banked_data_memory.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_banked_data_memory : directed + random traffic against a word-array model.
//                                                                 Rev 1.0
// ----------------------------------------------------------------------------
module tb_banked_data_memory;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int DEPTH      = 1024;
  localparam int BANKS      = 4;
  localparam int PORTS      = 3;
  localparam int ADDR_SHIFT = 2;

  logic clock  = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  banked_data_memory_if #(.PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  banked_data_memory #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .BANKS(BANKS), .PORTS(PORTS), .ADDR_SHIFT(ADDR_SHIFT)
  ) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  int                ptr_m [BANKS];
  int                win_m [BANKS];
  logic [PORTS-1:0]  exp_gnt, exp_rvalid, exp_err, seen_gnt;
  logic [DATA_W-1:0] exp_rdata [PORTS];
  int                wait_cnt [PORTS];
  int                max_wait = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [ADDR_W-1:0] a);
    return 32'(a) >> ADDR_SHIFT;
  endfunction

  task automatic reset_model();
    for (int b = 0; b < BANKS; b++) ptr_m[b] = 0;
    exp_rvalid = '0;
    exp_err    = '0;
    for (int p = 0; p < PORTS; p++) exp_rdata[p] = '0;
  endtask

  // Expected grants for the inputs presented this cycle.
  task automatic comb_check(input string tag);
    int unsigned w;
    int          pp;
    #2;
    exp_gnt = '0;
    for (int b = 0; b < BANKS; b++) win_m[b] = -1;
    if (nReset) begin
      for (int p = 0; p < PORTS; p++)
        if (bus.req[p] && word_of(bus.addr[p]) >= DEPTH) exp_gnt[p] = 1'b1;
      for (int b = 0; b < BANKS; b++) begin
        for (int k = 0; k < PORTS; k++) begin
          pp = (ptr_m[b] + k) % PORTS;
          w  = word_of(bus.addr[pp]);
          if (win_m[b] < 0 && bus.req[pp] && w < DEPTH && (w % BANKS) == b) begin
            win_m[b]    = pp;
            exp_gnt[pp] = 1'b1;
          end
        end
      end
    end
    seen_gnt = bus.gnt;
    chk({tag, "_gnt"}, bus.gnt, exp_gnt);
  endtask

  // Apply the granted accesses to the model, clock once, check registered outputs.
  task automatic clk_advance(input string tag);
    int unsigned w;
    logic [PORTS-1:0] nv, ne;
    nv = '0;
    ne = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (exp_gnt[p]) begin
        w = word_of(bus.addr[p]);
        if (!bus.we[p]) begin
          nv[p]        = 1'b1;
          exp_rdata[p] = (w < DEPTH) ? mem_m[w] : '0;
        end
        if (w >= DEPTH) ne[p] = 1'b1;
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      w = word_of(bus.addr[p]);
      if (exp_gnt[p] && bus.we[p] && w < DEPTH) mem_m[w] = bus.wdata[p];
    end
    for (int b = 0; b < BANKS; b++)
      if (win_m[b] >= 0) ptr_m[b] = (win_m[b] + 1) % PORTS;
    exp_rvalid = nv;
    exp_err    = ne;
    @(posedge clock);
    #1;
    chk({tag, "_rvalid"}, bus.rvalid, exp_rvalid);
    chk({tag, "_err"}, bus.err, exp_err);
    for (int p = 0; p < PORTS; p++) chk({tag, "_rdata"}, bus.rdata[p], exp_rdata[p]);
  endtask

  // Hold every presented request until the DUT grants it, within a cycle budget.
  task automatic run_txns(input string tag);
    for (int n = 0; n < 8 && bus.req != '0; n++) begin
      comb_check(tag);
      clk_advance(tag);
      bus.req = bus.req & ~seen_gnt;
    end
    chk({tag, "_timeout"}, bus.req, '0);
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req[p]   = r;
    bus.we[p]    = w;
    bus.addr[p]  = a;
    bus.wdata[p] = d;
  endtask

  task automatic new_txn(input int p);
    int unsigned w;
    w = ($urandom_range(9) == 0) ? $urandom_range(16383, 1024) : $urandom_range(31);
    set_port(p, $urandom_range(3) != 0, 1'($urandom_range(1)),
             ADDR_W'((w << ADDR_SHIFT) | $urandom_range(3)), DATA_W'($urandom));
  endtask

  initial begin
    logic found;
    reset_model();
    for (int p = 0; p < PORTS; p++) wait_cnt[p] = 0;

    // Reset held with all ports requesting; the same writes form the conflict test.
    nReset = 1'b0;
    set_port(0, 1'b1, 1'b1, 16'h0000, DATA_W'($urandom));
    set_port(1, 1'b1, 1'b1, 16'h0010, DATA_W'($urandom));
    set_port(2, 1'b1, 1'b1, 16'h0020, DATA_W'($urandom));
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_rvalid", bus.rvalid, '0);
    chk("rst_err", bus.err, '0);
    for (int p = 0; p < PORTS; p++) chk("rst_rdata", bus.rdata[p], '0);
    nReset = 1'b1;

    comb_check("conf0"); chk("conf0_order", bus.gnt, 3'b001); clk_advance("conf0"); bus.req[0] = 1'b0;
    comb_check("conf1"); chk("conf1_order", bus.gnt, 3'b010); clk_advance("conf1"); bus.req[1] = 1'b0;
    comb_check("conf2"); chk("conf2_order", bus.gnt, 3'b100); clk_advance("conf2"); bus.req[2] = 1'b0;
    bus.we = '0;
    bus.req = '1;
    run_txns("conf_rb");

    for (int i = 0; i < 32; i++) begin
      bus.req = '0;
      set_port(0, 1'b1, 1'b1, ADDR_W'(i << ADDR_SHIFT), DATA_W'($urandom));
      run_txns("init");
    end

    set_port(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    comb_check("sp_w"); chk("sp_w_gnt0", bus.gnt[0], 1'b1); clk_advance("sp_w");
    set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    comb_check("sp_r"); chk("sp_r_gnt0", bus.gnt[0], 1'b1); clk_advance("sp_r");
    chk("sp_rvalid0", bus.rvalid[0], 1'b1);
    chk("sp_rdata0", bus.rdata[0], 16'hBEEF);
    bus.req = '0;

    set_port(0, 1'b1, 1'b1, 16'h0000, 16'h1111);
    set_port(1, 1'b1, 1'b1, 16'h0004, 16'h2222);
    set_port(2, 1'b1, 1'b1, 16'h0008, 16'h3333);
    run_txns("par_w");
    bus.req = '1;
    bus.we  = '0;
    comb_check("par_r"); chk("par_all_gnt", bus.gnt, 3'b111); clk_advance("par_r");
    chk("par_rvalid", bus.rvalid, 3'b111);
    chk("par_rdata0", bus.rdata[0], 16'h1111);
    chk("par_rdata1", bus.rdata[1], 16'h2222);
    chk("par_rdata2", bus.rdata[2], 16'h3333);
    bus.req = '0;

    set_port(1, 1'b1, 1'b0, 16'h1000, 16'h0000);
    set_port(2, 1'b1, 1'b1, 16'h1000, 16'hDEAD);
    comb_check("oor"); chk("oor_gnt", bus.gnt, 3'b110); clk_advance("oor");
    chk("oor_rvalid1", bus.rvalid[1], 1'b1);
    chk("oor_rdata1", bus.rdata[1], 16'h0000);
    chk("oor_err", bus.err, 3'b110);
    bus.req = '0;
    comb_check("oor_idle"); clk_advance("oor_idle");
    chk("oor_err_pulse", bus.err, '0);
    bus.req = '1;
    bus.we  = '0;
    run_txns("oor_rb");
    chk("oor_rb_word0", bus.rdata[0], 16'h1111);

    bus.req = '0;
    for (int n = 0; n < 600; n++) begin
      comb_check("rnd");
      clk_advance("rnd");
      for (int p = 0; p < PORTS; p++) begin
        if (!bus.req[p] || seen_gnt[p]) begin
          wait_cnt[p] = 0;
          new_txn(p);
        end else if ($urandom_range(15) == 0) begin
          wait_cnt[p] = 0;
          bus.req[p]  = 1'b0;
        end else begin
          wait_cnt[p]++;
          if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
        end
      end
    end
    chk("rnd_wait_bound", (max_wait <= PORTS - 1), 1'b1);

    // Port0 and port2 contend for bank 0; catch a cycle with port0 winning and a read in flight.
    bus.req = '0;
    set_port(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    set_port(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      comb_check("ra");
      if (exp_gnt == 3'b001 && exp_rvalid != '0) found = 1'b1;
      else clk_advance("ra");
    end
    chk("ra_pre_rvalid", (bus.rvalid != '0), 1'b1);
    #1 nReset = 1'b0;
    #1;
    chk("ra_gnt_clear", bus.gnt, '0);
    chk("ra_rvalid_clear", bus.rvalid, '0);
    chk("ra_err_clear", bus.err, '0);
    for (int p = 0; p < PORTS; p++) chk("ra_rdata_clear", bus.rdata[p], '0);
    reset_model();
    repeat (2) @(posedge clock);
    #1 nReset = 1'b1;
    comb_check("ra_post"); chk("ra_post_first", bus.gnt, 3'b001); clk_advance("ra_post");
    comb_check("ra_post2"); chk("ra_post_second", bus.gnt, 3'b100); clk_advance("ra_post2");
    bus.req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/banked_data_memory.md
# banked_data_memory

Parametrised multi-port data memory, successor to the fixed three-port data memory in the datapath. It serves `PORTS` independent requesters from `BANKS` single-ported banks interleaved on word address. A per-bank round-robin arbiter resolves bank conflicts with a req/gnt handshake. Reads are registered, and out-of-range accesses are flagged. It sits between the load/store units and on-chip data storage.

## Interface
- `DATA_W`, 16, data word width
- `ADDR_W`, 16, byte-address width per port
- `DEPTH`, 1024, total words across all banks; multiple of `BANKS`
- `BANKS`, 4, number of interleaved banks; power of two
- `PORTS`, 3, number of requester ports
- `ADDR_SHIFT`, 2, byte-to-word shift; word index = `addr >> ADDR_SHIFT`

- `clock`  in  1  single clock; all state updates on rising edge
- `nReset`  in  1  asynchronous, active-low reset
- `req`  in  `PORTS`  per-port access request
- `we`  in  `PORTS`  per-port write (1) / read (0); valid with `req`
- `addr`  in  `PORTS`×`ADDR_W`  per-port byte address
- `wdata`  in  `PORTS`×`DATA_W`  per-port write data
- `gnt`  out  `PORTS`  access accepted this cycle (combinational)
- `rvalid`  out  `PORTS`  read data valid (registered)
- `rdata`  out  `PORTS`×`DATA_W`  read data (registered)
- `err`  out  `PORTS`  one-cycle pulse for an out-of-range access

## Operation
- Word index `w = addr[p] >> ADDR_SHIFT`. Bank `b = w % BANKS`. Row = `w / BANKS`.
- In range means `w < DEPTH`. An out-of-range request bypasses arbitration:
  - It is granted in the same cycle.
  - A write is dropped.
  - A read returns 0 with `rvalid=1`.
  - `err[p]=1` in the following cycle, for both reads and writes.
- Each bank accepts one access per cycle. When several ports target the same bank, its round-robin arbiter grants exactly one.
- Arbiter priority pointer per bank, reset value 0:
  - Search starts at the pointer index and wraps modulo `PORTS`.
  - On a grant to port p, the pointer becomes `(p+1) % PORTS`.
  - With no grant, the pointer holds.
- Ports targeting different banks are all granted in the same cycle.
- Handshake: the requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. Dropping `req` before `gnt` is legal and withdraws the request without side effect.
- A granted write updates the bank row at the clock edge.
- A granted read captures the row into `rdata[p]` and asserts `rvalid[p]` for one cycle.
- Read-after-write from any port in a later cycle returns the new data. The same bank cannot be read and written in one cycle by construction.
- `rdata[p]` holds its last value when `rvalid[p]=0`. There is no tri-state output.
- Memory contents are not reset and are undefined after power-up.

## Timing
- `gnt` is combinational from `req`/`addr` plus the pointer state in the same cycle. `gnt` is forced to 0 while `nReset=0`.
- Read latency is 1 cycle: grant in cycle N, then `rvalid`/`rdata` in cycle N+1.
- Write takes effect at the edge that ends grant cycle N. `err` for any access appears in cycle N+1.
- Back-to-back grants to one port on consecutive cycles give continuous `rvalid`.
- Worst-case wait for a persistently requesting port is `PORTS-1` cycles.
- Reset values: `rvalid=0`, `rdata=0`, `err=0`, all pointers 0.
- Reset asserted mid-operation:
  - Outputs clear immediately.
  - Any in-flight read is lost.
  - Pending requesters see `gnt=0` and must re-present after reset release.

## Structure
- Package `banked_mem_pkg`:
  - Localparams `BANK_W = $clog2(BANKS)`, `ROW_W = $clog2(DEPTH/BANKS)`, `PORT_W = $clog2(PORTS)`.
  - Functions `bank_of(addr)`, `row_of(addr)`, `in_range(addr)`.
- Sub-module `rr_arbiter`, parametrised by `PORTS`:
  - Inputs: request vector, grant-taken strobe.
  - Outputs: one-hot grant and the registered pointer.
  - One instance per bank.
- Bank storage: generate loop of `BANKS` arrays of `DEPTH/BANKS` words.

## Test plan
- Reset:
  - Stimulus: hold `nReset=0` with `req=3'b111`.
  - Required: `gnt=0`, `rvalid=0`, `rdata=0`, `err=0`.
- Single-port write then read:
  - Stimulus: port0 writes 0xBEEF at addr 0x0010, then reads 0x0010.
  - Required: `gnt[0]` in both cycles; `rvalid[0]=1` and `rdata[0]=0xBEEF` one cycle after the read grant.
- Parallel reads to distinct banks:
  - Stimulus: ports 0/1/2 read 0x0000/0x0004/0x0008, preloaded with 0x1111/0x2222/0x3333.
  - Required: all granted in cycle N; all `rvalid` in N+1 with the matching data.
- Same-bank conflict:
  - Stimulus: ports 0/1/2 all hold writes to bank 0 (0x0000/0x0010/0x0020) from reset.
  - Required: grants in order port0, port1, port2 over three cycles, one per cycle; readback confirms all three values.
- Out-of-range access:
  - Stimulus: port1 reads 0x1000 (word 1024); port2 writes 0xDEAD to 0x1000.
  - Required: both granted immediately; next cycle `rdata[1]=0`, `rvalid[1]=1`, `err[1]=err[2]=1`; no bank contents change.
- Reset mid-arbitration:
  - Stimulus: port2 is waiting behind port0 when `nReset` pulses low.
  - Required: `gnt` and `rvalid` clear asynchronously; after release with both still requesting, port0 is granted first.
